eth_tx_arbiter: RTL

- Shares the single AXI Ethernet TX core between NUM_SRC frame producers (e.g. ARP responder, ping responder, UDP transmitter).
- Each source presents complete Ethernet frames as a 32-bit AXI-Stream with tkeep/tlast.
- The block picks one source round-robin and emits the CTRL_WORDS-word control stream on eth_txc_*. It then passes the granted frame unchanged onto eth_txd_* and holds the grant until tlast.

---
 rtl/eth_tx_pkg.sv | 26 ++
 rtl/rr_grant_sel.sv | 29 ++
 rtl/eth_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types, defaults and per-source slice helpers for the Ethernet TX arbiter.
package eth_tx_pkg;

  localparam int unsigned MaxSrc       = 8;
  localparam int unsigned SrcIdxW      = 3;
  localparam int unsigned CtrlWordsDef = 6;
  localparam logic [31:0] CtrlFlagDef  = 32'hA000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCtrl,
    StData
  } tx_state_e;

  // Callers zero-extend their packed source vectors to MaxSrc lanes.
  function automatic logic [31:0] src_tdata(input logic [MaxSrc*32-1:0] vec,
                                            input logic [SrcIdxW-1:0]   k);
    return vec[{k, 5'd0} +: 32];
  endfunction

  function automatic logic [3:0] src_tkeep(input logic [MaxSrc*4-1:0] vec,
                                           input logic [SrcIdxW-1:0]  k);
    return vec[{k, 2'd0} +: 4];
  endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational round-robin picker: first set request above last_i, wrapping around.
module rr_grant_sel #(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] last_i,
  output logic                       any_o,
  output logic [$clog2(NUM_SRC)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);

  always_comb begin
    logic             found;
    logic [IdxW-1:0]  cand;
    found = 1'b0;
    cand  = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = IdxW'((32'(last_i) + i) % NUM_SRC);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one Ethernet TX core: per frame, a control transfer on
// eth_txc followed by the granted source's frame passed through on eth_txd.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WORDS = CtrlWordsDef,
  parameter logic [31:0] CTRL_FLAG  = CtrlFlagDef
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  output logic                              eth_txc_tvalid,
  output logic [31:0]                       eth_txc_tdata,
  output logic [3:0]                        eth_txc_tkeep,
  output logic                              eth_txc_tlast,
  input  logic                              eth_txc_tready,
  output logic                              eth_txd_tvalid,
  output logic [31:0]                       eth_txd_tdata,
  output logic [3:0]                        eth_txd_tkeep,
  output logic                              eth_txd_tlast,
  input  logic                              eth_txd_tready,
  output logic [$clog2(NUM_SRC)-1:0]        grant,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(CTRL_WORDS);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic            frame_done_q, frame_done_d;

  logic            pick_any;
  logic [IdxW-1:0] pick_idx;

  logic [MaxSrc*32-1:0] tdata_ext;
  logic [MaxSrc*4-1:0]  tkeep_ext;
  logic                 ctrl_last;
  logic                 src_valid;
  logic                 src_last;

  rr_grant_sel #(
    .NUM_SRC(NUM_SRC)
  ) u_rr_grant_sel (
    .req_i (s_axis_tvalid),
    .last_i(last_grant_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    tdata_ext = '0;
    tkeep_ext = '0;
    tdata_ext[NUM_SRC*DATA_WIDTH-1:0]   = s_axis_tdata;
    tkeep_ext[NUM_SRC*DATA_WIDTH/8-1:0] = s_axis_tkeep;
  end

  assign ctrl_last = (ctrl_cnt_q == CntW'(CTRL_WORDS - 1));
  assign src_valid = s_axis_tvalid[grant_q];
  assign src_last  = s_axis_tlast[grant_q];

  always_comb begin
    state_d        = state_q;
    ctrl_cnt_d     = ctrl_cnt_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    frame_done_d   = 1'b0;
    eth_txc_tvalid = 1'b0;
    eth_txc_tdata  = '0;
    eth_txc_tkeep  = '0;
    eth_txc_tlast  = 1'b0;
    eth_txd_tvalid = 1'b0;
    eth_txd_tdata  = '0;
    eth_txd_tkeep  = '0;
    eth_txd_tlast  = 1'b0;
    s_axis_tready  = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = StCtrl;
        end
      end

      StCtrl: begin
        eth_txc_tvalid = 1'b1;
        eth_txc_tkeep  = 4'hF;
        eth_txc_tdata  = (ctrl_cnt_q == '0) ? CTRL_FLAG : 32'h0;
        eth_txc_tlast  = ctrl_last;
        if (eth_txc_tready) begin
          if (ctrl_last) begin
            ctrl_cnt_d = '0;
            state_d    = StData;
          end else begin
            ctrl_cnt_d = ctrl_cnt_q + CntW'(1);
          end
        end
      end

      StData: begin
        // Pure pass-through: source bubbles show up as txd_tvalid low.
        eth_txd_tvalid         = src_valid;
        eth_txd_tdata          = src_tdata(tdata_ext, SrcIdxW'(grant_q));
        eth_txd_tkeep          = src_tkeep(tkeep_ext, SrcIdxW'(grant_q));
        eth_txd_tlast          = src_last;
        s_axis_tready[grant_q] = eth_txd_tready;
        if (src_valid && eth_txd_tready && src_last) begin
          last_grant_d = grant_q;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ctrl_cnt_q   <= '0;
      last_grant_q <= IdxW'(NUM_SRC - 1);
      grant_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_cnt_q   <= ctrl_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

endmodule
